// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Opcodes, FSM states, datapath select codes and fault bit indices.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_MDR = 2'b00;
  localparam logic [1:0] M2R_ALU = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  localparam int FLT_ILLEGAL = 0;
  localparam int FLT_TIMEOUT = 1;

  function automatic logic op_legal(logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_ANDI,
                      OP_BEQ, OP_JAL, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mips_ctrl_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on MemReady.
// Flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Any non-waiting cycle (state exit or entry) clears the count
  always_comb begin
    cnt_d = wait_i ? cnt_q + TO_W'(1) : '0;
  end

  assign expired_o = wait_i && (cnt_q == LIMIT);

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB strobes.
// Optional MEM_TIMEOUT_EN bounds MemReady waits and faults on expiry.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Run,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic       InstrDone,
  output logic [1:0] Fault
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [1:0] fault_q, fault_d;
  state_t     ret_st;
  logic       to_expired;

`ifdef MEM_TIMEOUT_EN
  logic wait_mem;
  assign wait_mem = (state_q == S_FETCH || state_q == S_MEM)
                    && !MemReady;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (wait_mem),
    .expired_o(to_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, TO_W};
  assign to_expired = 1'b0;
`endif

  assign ret_st = Run ? S_FETCH : S_IDLE;
  assign Fault  = fault_q;

  // State, latched opcode and sticky fault registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fault_q <= fault_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (to_expired) begin
          state_d = S_FAULT;
          fault_d[FLT_TIMEOUT] = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = OpCode;
        if (op_legal(OpCode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FAULT;
          fault_d[FLT_ILLEGAL] = 1'b1;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_RTYPE, OP_ADDI, OP_ANDI: state_d = S_WB;
          OP_LW, OP_SW:               state_d = S_MEM;
          OP_BEQ, OP_JAL:             state_d = ret_st;
          default:                    state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (MemReady) begin
          state_d = (op_q == OP_LW) ? S_WB : ret_st;
        end else if (to_expired) begin
          state_d = S_FAULT;
          fault_d[FLT_TIMEOUT] = 1'b1;
        end
      end
      S_WB:    state_d = ret_st;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes and selects per state and latched opcode
  always_comb begin
    PCWrite   = 1'b0;
    PCSource  = PCS_ALU;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = RD_RT;
    MemToReg  = M2R_MDR;
    AluSrcA   = 1'b0;
    AluSrcB   = SRCB_RT;
    AluOp     = ALU_ADD;
    InstrDone = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = SRCB_4;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      S_DECODE: begin
        AluSrcB = SRCB_BR;
      end
      S_EXEC: begin
        unique case (op_q)
          OP_RTYPE: begin
            AluSrcA = 1'b1;
            AluOp   = ALU_FUNCT;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            AluSrcA = 1'b1;
            AluSrcB = SRCB_IMM;
          end
          OP_ANDI: begin
            AluSrcA = 1'b1;
            AluSrcB = SRCB_IMM;
            AluOp   = ALU_AND;
          end
          OP_BEQ: begin
            AluSrcA   = 1'b1;
            AluOp     = ALU_SUB;
            PCSource  = PCS_BR;
            PCWrite   = Zero;
            InstrDone = 1'b1;
          end
          OP_JAL: begin
            RegWrite  = 1'b1;
            RegDst    = RD_RA;
            MemToReg  = M2R_PC;
            PCWrite   = 1'b1;
            PCSource  = PCS_JMP;
            InstrDone = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD      = 1'b1;
        MemRead   = (op_q == OP_LW);
        MemWrite  = (op_q == OP_SW);
        InstrDone = (op_q == OP_SW) && MemReady;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        unique case (op_q)
          OP_RTYPE: begin
            RegDst   = RD_RD;
            MemToReg = M2R_ALU;
          end
          OP_ADDI, OP_ANDI: MemToReg = M2R_ALU;
          default:          MemToReg = M2R_MDR;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl with an expected-output queue.
// Vectors are driven after posedge and compared at the following negedge.
module tb_multicycle_ctrl;

  localparam logic [5:0] B_R    = 6'b000000;
  localparam logic [5:0] B_ADDI = 6'b001000;
  localparam logic [5:0] B_ANDI = 6'b001100;
  localparam logic [5:0] B_BEQ  = 6'b000100;
  localparam logic [5:0] B_JAL  = 6'b000011;
  localparam logic [5:0] B_LW   = 6'b100011;
  localparam logic [5:0] B_SW   = 6'b101011;
  localparam logic [5:0] B_ILL  = 6'b111111;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       done;
    logic [1:0] flt;
  } out_t;

  typedef struct {
    logic       run;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    out_t       exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       Run;
  logic [5:0] OpCode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluOp;
  logic       InstrDone;
  logic [1:0] Fault;

  out_t act;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .TIMEOUT_CYCLES(4),
    .TO_W          (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Run      (Run),
    .OpCode   (OpCode),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .PCSource (PCSource),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemToReg (MemToReg),
    .AluSrcA  (AluSrcA),
    .AluSrcB  (AluSrcB),
    .AluOp    (AluOp),
    .InstrDone(InstrDone),
    .Fault    (Fault)
  );

  assign act = {PCWrite, PCSource, IorD, MemRead, MemWrite,
                IRWrite, RegWrite, RegDst, MemToReg, AluSrcA,
                AluSrcB, AluOp, InstrDone, Fault};

  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_fetch(logic rdy);
    out_t o = '0;
    o.mrd = 1'b1;
    o.asb = 2'b01;
    o.pcw = rdy;
    o.irw = rdy;
    return o;
  endfunction

  function automatic out_t o_dec();
    out_t o = '0;
    o.asb = 2'b11;
    return o;
  endfunction

  function automatic out_t o_ex_r();
    out_t o = '0;
    o.asa = 1'b1;
    o.aop = 3'b100;
    return o;
  endfunction

  function automatic out_t o_ex_imm(logic [2:0] aop);
    out_t o = '0;
    o.asa = 1'b1;
    o.asb = 2'b10;
    o.aop = aop;
    return o;
  endfunction

  function automatic out_t o_ex_beq(logic z);
    out_t o = '0;
    o.asa   = 1'b1;
    o.aop   = 3'b001;
    o.pcsrc = 2'b01;
    o.pcw   = z;
    o.done  = 1'b1;
    return o;
  endfunction

  function automatic out_t o_ex_jal();
    out_t o = '0;
    o.rgw   = 1'b1;
    o.rdst  = 2'b10;
    o.m2r   = 2'b10;
    o.pcw   = 1'b1;
    o.pcsrc = 2'b10;
    o.done  = 1'b1;
    return o;
  endfunction

  function automatic out_t o_mem(logic is_lw, logic rdy);
    out_t o = '0;
    o.iord = 1'b1;
    o.mrd  = is_lw;
    o.mwr  = !is_lw;
    o.done = !is_lw && rdy;
    return o;
  endfunction

  function automatic out_t o_wb(logic [1:0] dst, logic [1:0] m2r);
    out_t o = '0;
    o.rgw  = 1'b1;
    o.rdst = dst;
    o.m2r  = m2r;
    o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fault(logic [1:0] f);
    out_t o = '0;
    o.flt = f;
    return o;
  endfunction

  task automatic add(input logic run, input logic [5:0] op,
                     input logic z, input logic rdy,
                     input out_t e, input string n);
    vec_t v;
    v.run  = run;
    v.op   = op;
    v.z    = z;
    v.rdy  = rdy;
    v.exp  = e;
    v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input out_t e);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  // Scoreboard: compare the oldest pending expectation at each negedge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check(cur.name, cur.exp);
    end
  end

  task automatic run_vecs();
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      Run      = vecs[i].run;
      OpCode   = vecs[i].op;
      Zero     = vecs[i].z;
      MemReady = vecs[i].rdy;
      sb.push_back(vecs[i]);
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++)
      @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    vecs.delete();
  endtask

  initial begin
    rst      = 1'b1;
    Run      = 1'b0;
    OpCode   = B_R;
    Zero     = 1'b0;
    MemReady = 1'b0;
    #2;
    check("reset.state", o_idle());
    @(posedge clk);
    #1 rst = 1'b0;

    add(1, B_R, 0, 1, o_idle(),             "rt.idle_run");
    add(1, B_R, 0, 1, o_fetch(1),           "rt.fetch");
    add(1, B_R, 0, 1, o_dec(),              "rt.decode");
    add(1, B_R, 0, 1, o_ex_r(),             "rt.exec");
    add(1, B_R, 0, 1, o_wb(2'b01, 2'b01),   "rt.wb");
    for (int i = 0; i < 3; i++)
      add(1, B_LW, 0, 0, o_fetch(0),        "lw.fetch_wait");
    add(1, B_LW, 0, 1, o_fetch(1),          "lw.fetch");
    add(1, B_LW, 0, 1, o_dec(),             "lw.decode");
    add(1, B_LW, 0, 1, o_ex_imm(3'b000),    "lw.exec");
    for (int i = 0; i < 2; i++)
      add(1, B_LW, 0, 0, o_mem(1, 0),       "lw.mem_wait");
    add(1, B_LW, 0, 1, o_mem(1, 1),         "lw.mem");
    add(1, B_LW, 0, 1, o_wb(2'b00, 2'b00),  "lw.wb");
    add(1, B_BEQ, 1, 1, o_fetch(1),         "beq1.fetch");
    add(1, B_BEQ, 1, 1, o_dec(),            "beq1.decode");
    add(1, B_BEQ, 1, 1, o_ex_beq(1),        "beq1.exec_taken");
    add(1, B_BEQ, 0, 1, o_fetch(1),         "beq0.fetch");
    add(1, B_BEQ, 0, 1, o_dec(),            "beq0.decode");
    add(1, B_BEQ, 0, 1, o_ex_beq(0),        "beq0.exec_not");
    add(1, B_JAL, 0, 1, o_fetch(1),         "jal.fetch");
    add(1, B_JAL, 0, 1, o_dec(),            "jal.decode");
    add(1, B_JAL, 0, 1, o_ex_jal(),         "jal.exec");
    add(1, B_SW, 0, 1, o_fetch(1),          "sw.fetch");
    add(1, B_SW, 0, 1, o_dec(),             "sw.decode");
    add(1, B_SW, 0, 1, o_ex_imm(3'b000),    "sw.exec");
    add(1, B_SW, 0, 0, o_mem(0, 0),         "sw.mem_wait");
    add(0, B_SW, 0, 1, o_mem(0, 1),         "sw.mem_retire");
    add(0, B_SW, 0, 1, o_idle(),            "idle.after_sw");
    add(0, B_SW, 0, 1, o_idle(),            "idle.hold");
    add(1, B_ADDI, 0, 1, o_idle(),          "addi.idle_run");
    add(0, B_ADDI, 0, 1, o_fetch(1),        "addi.fetch_norun");
    add(0, B_ADDI, 0, 1, o_dec(),           "addi.decode");
    add(0, B_ADDI, 0, 1, o_ex_imm(3'b000),  "addi.exec");
    add(1, B_ADDI, 0, 1, o_wb(2'b00, 2'b01),"addi.wb");
    add(1, B_ANDI, 0, 1, o_fetch(1),        "andi.fetch");
    add(1, B_ANDI, 0, 1, o_dec(),           "andi.decode");
    add(1, B_ANDI, 0, 1, o_ex_imm(3'b011),  "andi.exec");
    add(0, B_ANDI, 0, 1, o_wb(2'b00, 2'b01),"andi.wb");
    add(0, B_ANDI, 0, 1, o_idle(),          "idle.after_andi");
    add(1, B_ILL, 0, 1, o_idle(),           "ill.idle_run");
    add(1, B_ILL, 0, 1, o_fetch(1),         "ill.fetch");
    add(1, B_ILL, 0, 1, o_dec(),            "ill.decode");
    for (int i = 0; i < 20; i++)
      add(1, B_ILL, 1, 1, o_fault(2'b01),   "ill.fault_hold");
    run_vecs();

    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst.fault_clear", o_idle());
    @(posedge clk);
    #1;
    rst      = 1'b0;
    Run      = 1'b1;
    MemReady = 1'b0;
    OpCode   = B_R;
    @(posedge clk);
    #1 check("rst.fetch_wait", o_fetch(0));
    #2 rst = 1'b1;
    #1 check("rst.async_drop", o_idle());
    @(posedge clk);
    #1;
    rst = 1'b0;
    Run = 1'b0;
    check("rst.idle", o_idle());

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      add(1, B_SW, 0, 0, o_fetch(0),        "to.fetch_wait");
    add(1, B_SW, 0, 1, o_fetch(1),          "to.fetch_at_limit");
    add(1, B_SW, 0, 1, o_dec(),             "to.sw_decode");
    add(1, B_SW, 0, 1, o_ex_imm(3'b000),    "to.sw_exec");
    for (int i = 0; i < 3; i++)
      add(1, B_SW, 0, 0, o_mem(0, 0),       "to.sw_wait");
    add(1, B_SW, 0, 1, o_mem(0, 1),         "to.sw_at_limit");
    add(1, B_LW, 0, 1, o_fetch(1),          "to.lw_fetch");
    add(1, B_LW, 0, 1, o_dec(),             "to.lw_decode");
    add(1, B_LW, 0, 1, o_ex_imm(3'b000),    "to.lw_exec");
    for (int i = 0; i < 4; i++)
      add(1, B_LW, 0, 0, o_mem(1, 0),       "to.lw_stuck");
    for (int i = 0; i < 3; i++)
      add(1, B_LW, 0, 1, o_fault(2'b10),    "to.fault");
    add(1, B_LW, 0, 1, o_idle(), "to.idle_run");
    vecs.pop_back();
    vecs.push_front(vecs[0]);
    vecs[0].rdy  = 1'b1;
    vecs[0].run  = 1'b1;
    vecs[0].exp  = o_idle();
    vecs[0].name = "to.idle_run";
    run_vecs();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
